// File: rtl/board_renderer_if.sv
// Bundle between the game control FSM (master) and the board renderer (slave):
// redraw request, board snapshot inputs and the VGA pixel stream plus status.
interface board_renderer_if #(
    parameter int N     = 3,
    parameter int IDX_W = 4
);
    logic                 start;
    logic [2*N*N-1:0]     grid;
    logic                 cursor_en;
    logic [IDX_W-1:0]     cursor_idx;
    logic [7:0]           x_out;
    logic [6:0]           y_out;
    logic [2:0]           colour_out;
    logic                 plot;
    logic                 busy;
    logic                 done;

    modport master (
        output start, grid, cursor_en, cursor_idx,
        input  x_out, y_out, colour_out, plot, busy, done
    );

    modport slave (
        input  start, grid, cursor_en, cursor_idx,
        output x_out, y_out, colour_out, plot, busy, done
    );
endinterface

// File: rtl/board_renderer.sv
// Walks an N x N board snapshot and streams one filled square per cell to the VGA
// adapter, one pixel per clock, with optional cursor-border highlight.
module board_renderer #(
    parameter int         N             = 3,
    parameter int         CELL          = 16,
    parameter int         PITCH         = 30,
    parameter int         X0            = 37,
    parameter int         Y0            = 7,
    parameter int         IDX_W         = 4,
    parameter logic [2:0] CURSOR_COLOUR = 3'b110
) (
    input  logic            clock,
    input  logic            resetn,
    board_renderer_if.slave bus
);
    localparam int CELLS  = N * N;
    localparam int GRID_W = 2 * CELLS;
    localparam int CELL_W = $clog2(CELLS);
    localparam int RC_W   = $clog2(N);
    localparam int PX_W   = $clog2(CELL);

    typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

    state_t              state_q, state_d;
    logic [CELL_W-1:0]   cell_q, cell_d;
    logic [RC_W-1:0]     row_q, row_d;
    logic [RC_W-1:0]     col_q, col_d;
    logic [PX_W-1:0]     px_q, px_d;
    logic [PX_W-1:0]     py_q, py_d;
    logic [GRID_W-1:0]   grid_q, grid_d;
    logic                cur_en_q, cur_en_d;
    logic [IDX_W-1:0]    cur_idx_q, cur_idx_d;
    logic [7:0]          x_q, x_d;
    logic [6:0]          y_q, y_d;
    logic [2:0]          colour_q, colour_d;
    logic                plot_q, plot_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [1:0]          cell_states [CELLS];
    logic [1:0]          cell_state;
    logic                on_border;
    logic                cursor_hit;
    logic                last_pixel;

    // Per-cell view of the next-cycle snapshot; cell 0 sits in the top bits.
    generate
        for (genvar gi = 0; gi < CELLS; gi++) begin : g_cell
            assign cell_states[gi] = grid_d[2*(CELLS-1-gi) +: 2];
        end
    endgenerate

    assign last_pixel = (px_q == PX_W'(CELL-1)) && (py_q == PX_W'(CELL-1))
                     && (cell_q == CELL_W'(CELLS-1));

    // Control and counters. The *_d counters always describe the pixel that the
    // output registers will present next cycle.
    always_comb begin
        state_d   = state_q;
        cell_d    = cell_q;
        row_d     = row_q;
        col_d     = col_q;
        px_d      = px_q;
        py_d      = py_q;
        grid_d    = grid_q;
        cur_en_d  = cur_en_q;
        cur_idx_d = cur_idx_q;
        plot_d    = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    grid_d    = bus.grid;
                    cur_en_d  = bus.cursor_en;
                    cur_idx_d = bus.cursor_idx;
                    cell_d    = '0;
                    row_d     = '0;
                    col_d     = '0;
                    px_d      = '0;
                    py_d      = '0;
                    plot_d    = 1'b1;
                    busy_d    = 1'b1;
                    state_d   = DRAW;
                end
            end
            DRAW: begin
                if (last_pixel) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    plot_d = 1'b1;
                    busy_d = 1'b1;
                    if (px_q == PX_W'(CELL-1)) begin
                        px_d = '0;
                        if (py_q == PX_W'(CELL-1)) begin
                            py_d   = '0;
                            cell_d = cell_q + CELL_W'(1);
                            if (col_q == RC_W'(N-1)) begin
                                col_d = '0;
                                row_d = row_q + RC_W'(1);
                            end else begin
                                col_d = col_q + RC_W'(1);
                            end
                        end else begin
                            py_d = py_q + PX_W'(1);
                        end
                    end else begin
                        px_d = px_q + PX_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pixel decode for the next cycle; outputs hold their last value outside DRAW.
    always_comb begin
        x_d        = x_q;
        y_d        = y_q;
        colour_d   = colour_q;
        cell_state = cell_states[cell_d];
        on_border  = (px_d == '0) || (px_d == PX_W'(CELL-1))
                  || (py_d == '0) || (py_d == PX_W'(CELL-1));
        cursor_hit = cur_en_d && (32'(cur_idx_d) == 32'(cell_d));

        if (state_d == DRAW) begin
            x_d = 8'(X0 + 32'(col_d) * PITCH + 32'(px_d));
            y_d = 7'(Y0 + 32'(row_d) * PITCH + 32'(py_d));
            if (cursor_hit && on_border) begin
                colour_d = CURSOR_COLOUR;
            end else begin
                unique case (cell_state)
                    2'd0:    colour_d = 3'b111;
                    2'd1:    colour_d = 3'b011;
                    2'd2:    colour_d = 3'b101;
                    default: colour_d = 3'b100;
                endcase
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            cell_q    <= '0;
            row_q     <= '0;
            col_q     <= '0;
            px_q      <= '0;
            py_q      <= '0;
            grid_q    <= '0;
            cur_en_q  <= 1'b0;
            cur_idx_q <= '0;
            x_q       <= '0;
            y_q       <= '0;
            colour_q  <= '0;
            plot_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cell_q    <= cell_d;
            row_q     <= row_d;
            col_q     <= col_d;
            px_q      <= px_d;
            py_q      <= py_d;
            grid_q    <= grid_d;
            cur_en_q  <= cur_en_d;
            cur_idx_q <= cur_idx_d;
            x_q       <= x_d;
            y_q       <= y_d;
            colour_q  <= colour_d;
            plot_q    <= plot_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.x_out      = x_q;
    assign bus.y_out      = y_q;
    assign bus.colour_out = colour_q;
    assign bus.plot       = plot_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_board_renderer.sv
// Scoreboard bench for board_renderer: default 3x3 board and a 4x4 small-cell
// variant, expected pixel streams generated from the board rules.
module tb_board_renderer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    pix_t qa[$];
    pix_t qb[$];
    int   exp_len_a = 0, exp_len_b = 0;
    int   plots_a = 0, plots_b = 0;
    bit   prev_plot_a = 0, prev_done_a = 0, prev_plot_b = 0, prev_done_b = 0;
    pix_t got_a, exp_a, got_b, exp_b, last_a, last_b;

    board_renderer_if #(.N(3), .IDX_W(4)) bus_a();
    board_renderer_if #(.N(4), .IDX_W(4)) bus_b();

    board_renderer dut_a (.clock(clk), .resetn(rst_n), .bus(bus_a));
    board_renderer #(.N(4), .CELL(4), .PITCH(6), .X0(0), .Y0(0), .IDX_W(4))
        dut_b (.clock(clk), .resetn(rst_n), .bus(bus_b));

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [2:0] state_colour(input int s);
        case (s)
            0:       return 3'b111;
            1:       return 3'b011;
            2:       return 3'b101;
            default: return 3'b100;
        endcase
    endfunction

    // Reference: every cell in row-major order, a CELL x CELL square, x fastest.
    task automatic push_frame(input int which, input int n, input int cs, input int pitch,
                              input int x0, input int y0, input logic [127:0] g,
                              input bit cen, input int cidx);
        logic [127:0] t;
        pix_t p;
        for (int k = 0; k < n*n; k++) begin
            int row = k / n;
            int col = k % n;
            int s;
            t = g >> (2*(n*n-1-k));
            s = int'(t[1:0]);
            for (int py = 0; py < cs; py++) begin
                for (int px = 0; px < cs; px++) begin
                    bit border = (px == 0) || (px == cs-1) || (py == 0) || (py == cs-1);
                    p.x = 8'(x0 + col*pitch + px);
                    p.y = 7'(y0 + row*pitch + py);
                    p.c = (cen && k == cidx && border) ? 3'b110 : state_colour(s);
                    if (which == 0) qa.push_back(p); else qb.push_back(p);
                end
            end
        end
        if (which == 0) exp_len_a = n*n*cs*cs; else exp_len_b = n*n*cs*cs;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            plots_a = 0; prev_plot_a = 0; prev_done_a = 0;
        end else begin
            if (bus_a.plot) begin
                chk("a_busy_with_plot", int'(bus_a.busy), 1);
                got_a = '{bus_a.x_out, bus_a.y_out, bus_a.colour_out};
                if (qa.size() == 0) begin
                    chk("a_unexpected_plot", 1, 0);
                end else begin
                    exp_a = qa.pop_front();
                    n_cmp++;
                    if (got_a !== exp_a) begin
                        n_bad++;
                        $display("FAIL a_pixel #%0d: got (%0d,%0d) c=%0d expected (%0d,%0d) c=%0d",
                                 plots_a, got_a.x, got_a.y, got_a.c, exp_a.x, exp_a.y, exp_a.c);
                    end
                end
                plots_a++;
                last_a = got_a;
            end
            if (bus_a.done) begin
                chk("a_done_after_last_plot", int'(prev_plot_a), 1);
                chk("a_busy_at_done", int'(bus_a.busy), 0);
                chk("a_plot_count", plots_a, exp_len_a);
                chk("a_queue_drained", qa.size(), 0);
                plots_a = 0;
            end
            if (prev_done_a) chk("a_done_one_cycle", int'(bus_a.done), 0);
            prev_plot_a = bus_a.plot;
            prev_done_a = bus_a.done;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            plots_b = 0; prev_plot_b = 0; prev_done_b = 0;
        end else begin
            if (bus_b.plot) begin
                got_b = '{bus_b.x_out, bus_b.y_out, bus_b.colour_out};
                if (qb.size() == 0) begin
                    chk("b_unexpected_plot", 1, 0);
                end else begin
                    exp_b = qb.pop_front();
                    n_cmp++;
                    if (got_b !== exp_b) begin
                        n_bad++;
                        $display("FAIL b_pixel #%0d: got (%0d,%0d) c=%0d expected (%0d,%0d) c=%0d",
                                 plots_b, got_b.x, got_b.y, got_b.c, exp_b.x, exp_b.y, exp_b.c);
                    end
                end
                plots_b++;
                last_b = got_b;
            end
            if (bus_b.done) begin
                chk("b_done_after_last_plot", int'(prev_plot_b), 1);
                chk("b_busy_at_done", int'(bus_b.busy), 0);
                chk("b_plot_count", plots_b, exp_len_b);
                plots_b = 0;
            end
            if (prev_done_b) chk("b_done_one_cycle", int'(bus_b.done), 0);
            prev_plot_b = bus_b.plot;
            prev_done_b = bus_b.done;
        end
    end

    task automatic wait_done_a();
        int i;
        for (i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (bus_a.done) break;
        end
        chk("a_done_seen", int'(i < 3000), 1);
        // start raised during the DONE cycle must not launch a frame
        bus_a.start = 1'b1;
        @(posedge clk); #1 bus_a.start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("a_idle_after_done", int'(bus_a.plot | bus_a.busy), 0);
        end
    endtask

    task automatic run_a(input logic [17:0] g, input bit cen, input int cidx, input bit disturb);
        @(posedge clk); #1;
        bus_a.grid = g; bus_a.cursor_en = cen; bus_a.cursor_idx = 4'(cidx); bus_a.start = 1'b1;
        push_frame(0, 3, 16, 30, 37, 7, 128'(g), cen, cidx);
        @(posedge clk); #1 bus_a.start = 1'b0;
        chk("a_first_plot", int'(bus_a.plot), 1);
        chk("a_first_busy", int'(bus_a.busy), 1);
        if (disturb) begin
            repeat (700) @(posedge clk);
            #1 bus_a.grid = ~g; bus_a.cursor_en = ~cen; bus_a.cursor_idx = 4'd0; bus_a.start = 1'b1;
            @(posedge clk); #1 bus_a.start = 1'b0;
        end
        wait_done_a();
    endtask

    task automatic run_b(input logic [31:0] g, input bit cen, input int cidx);
        int i;
        @(posedge clk); #1;
        bus_b.grid = g; bus_b.cursor_en = cen; bus_b.cursor_idx = 4'(cidx); bus_b.start = 1'b1;
        push_frame(1, 4, 4, 6, 0, 0, 128'(g), cen, cidx);
        @(posedge clk); #1 bus_b.start = 1'b0;
        chk("b_first_plot", int'(bus_b.plot), 1);
        for (i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus_b.done) break;
        end
        chk("b_done_seen", int'(i < 400), 1);
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_a.start = 0; bus_a.grid = '0; bus_a.cursor_en = 0; bus_a.cursor_idx = '0;
        bus_b.start = 0; bus_b.grid = '0; bus_b.cursor_en = 0; bus_b.cursor_idx = '0;
        #12;
        chk("rst_a_plot", int'(bus_a.plot), 0);
        chk("rst_a_busy", int'(bus_a.busy), 0);
        chk("rst_a_done", int'(bus_a.done), 0);
        chk("rst_a_xyc", int'({bus_a.x_out, bus_a.y_out, bus_a.colour_out}), 0);
        chk("rst_b_plot", int'(bus_b.plot), 0);
        @(negedge clk); #1 rst_n = 1'b1;

        // Empty board: every pixel white, frame spans (37,7)..(112,82)
        run_a(18'd0, 1'b0, 0, 1'b0);
        chk("a_last_x", int'(last_a.x), 112);
        chk("a_last_y", int'(last_a.y), 82);
        run_a(18'b01_10_00_00_11_00_00_00_10, 1'b0, 0, 1'b0);
        run_a(18'h15555, 1'b1, 4, 1'b0);
        run_a(18'h15555, 1'b1, 9, 1'b0);
        run_a(18'($urandom), 1'b1, 2, 1'b1);
        repeat (3) run_a(18'($urandom), 1'($urandom), int'($urandom_range(0, 15)), 1'b0);

        // Asynchronous reset mid-frame, then a fresh frame
        @(posedge clk); #1;
        bus_a.grid = 18'($urandom); bus_a.cursor_en = 0; bus_a.start = 1'b1;
        push_frame(0, 3, 16, 30, 37, 7, 128'(bus_a.grid), 1'b0, 0);
        @(posedge clk); #1 bus_a.start = 1'b0;
        for (int i = 0; i < 1500 && plots_a < 1000; i++) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_plot", int'(bus_a.plot), 0);
        chk("mid_rst_busy", int'(bus_a.busy), 0);
        chk("mid_rst_done", int'(bus_a.done), 0);
        chk("mid_rst_x", int'(bus_a.x_out), 0);
        qa.delete();
        repeat (3) @(negedge clk);
        chk("held_rst_plot", int'(bus_a.plot), 0);
        #1 rst_n = 1'b1;
        run_a(18'b11_00_01_10_00_01_10_11_00, 1'b1, 8, 1'b0);

        // Small variant: 4x4 board of 4-pixel cells, ends at (21,21)
        run_b(32'd0, 1'b0, 0);
        chk("b_last_x", int'(last_b.x), 21);
        chk("b_last_y", int'(last_b.y), 21);
        run_b(32'hFFFF_FFFF, 1'b1, 15);
        repeat (4) run_b($urandom, 1'($urandom), int'($urandom_range(0, 15)));

        repeat (4) @(negedge clk);
        chk("a_queue_empty_end", qa.size(), 0);
        chk("b_queue_empty_end", qb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
